core_trap_unit: RTL and testbench

- Writer side of the core's implicitly-written CSR path.
- Accepts exception, interrupt and xRET requests from s2 and computes privilege-mode, mstatus, xepc, xcause and xtval updates from the implicitly-read CSRs.
- Drives the implicit CSR write enables into core_csr_file, then redirects fetch in s1 to the trap vector or return address.
- Sits beside core_master_control inside core_top.

---
 rtl/core_pkg.sv | 63 ++++++
 rtl/core_trap_irq_select.sv | 52 +++++
 rtl/core_trap_unit.sv | 278 +++++++++++++++++++++++++++
 tb/tb_core_trap_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types: privilege modes, trap kinds, cause codes
// and the mstatus bit positions used by the trap path.
package core_pkg;

    typedef enum logic [1:0] {
        PRV_U = 2'b00,
        PRV_S = 2'b01,
        PRV_M = 2'b11
    } prv_mode_t;

    typedef enum logic [1:0] {
        TRAP_EXC,
        TRAP_IRQ,
        TRAP_MRET,
        TRAP_SRET
    } trap_kind_e;

    typedef enum logic [4:0] {
        EXC_INSN_MISALIGN  = 5'd0,
        EXC_INSN_FAULT     = 5'd1,
        EXC_ILLEGAL_INSN   = 5'd2,
        EXC_BREAKPOINT     = 5'd3,
        EXC_LOAD_MISALIGN  = 5'd4,
        EXC_LOAD_FAULT     = 5'd5,
        EXC_STORE_MISALIGN = 5'd6,
        EXC_STORE_FAULT    = 5'd7,
        EXC_ECALL_U        = 5'd8,
        EXC_ECALL_S        = 5'd9,
        EXC_ECALL_M        = 5'd11,
        EXC_INSN_PAGE      = 5'd12,
        EXC_LOAD_PAGE      = 5'd13,
        EXC_STORE_PAGE     = 5'd15
    } exc_cause_e;

    typedef enum logic [4:0] {
        IRQ_SSI = 5'd1,
        IRQ_MSI = 5'd3,
        IRQ_STI = 5'd5,
        IRQ_MTI = 5'd7,
        IRQ_SEI = 5'd9,
        IRQ_MEI = 5'd11
    } irq_cause_e;

    localparam int MSTATUS_SIE    = 1;
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_SPIE   = 5;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_SPP    = 8;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MSTATUS_MPRV   = 17;

    // Index 0 is the highest-priority fixed interrupt.
    localparam logic [4:0] IRQ_ORDER [6] = '{
        IRQ_MEI, IRQ_MSI, IRQ_MTI, IRQ_SEI, IRQ_SSI, IRQ_STI
    };

    function automatic logic irq_is_fixed(input logic [4:0] c);
        return (c == IRQ_MEI) || (c == IRQ_MSI) || (c == IRQ_MTI) ||
               (c == IRQ_SEI) || (c == IRQ_SSI) || (c == IRQ_STI);
    endfunction

endpackage

// File: rtl/core_trap_irq_select.sv
// Interrupt enable, delegation and fixed-priority selection.
// Purely combinational; evaluated by the trap unit while idle.
module core_trap_irq_select
    import core_pkg::*;
#(
    parameter int NUM_IRQ = 12
) (
    input  logic [NUM_IRQ-1:0] mip,
    input  logic [NUM_IRQ-1:0] mie,
    input  logic [NUM_IRQ-1:0] mideleg,
    input  logic               sie_en,
    input  logic               mie_en,
    input  logic [1:0]         prv,
    output logic               irq_valid,
    output logic [4:0]         irq_cause,
    output logic               irq_to_s
);

    logic [31:0] take;
    logic [31:0] deleg;

    always_comb begin
        take  = '0;
        deleg = '0;
        deleg[NUM_IRQ-1:0] = mideleg;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (mip[i] && mie[i]) begin
                if (mideleg[i])
                    take[i] = (prv == PRV_U) || ((prv == PRV_S) && sie_en);
                else
                    take[i] = (prv != PRV_M) || mie_en;
            end
        end
    end

    // Remaining bits first (highest wins), then fixed order overrides.
    always_comb begin
        irq_cause = '0;
        for (int i = 0; i < 32; i++) begin
            if (take[i] && !irq_is_fixed(5'(i)))
                irq_cause = 5'(i);
        end
        for (int k = 5; k >= 0; k--) begin
            if (take[IRQ_ORDER[k]])
                irq_cause = IRQ_ORDER[k];
        end
    end

    assign irq_valid = |take;
    assign irq_to_s  = deleg[irq_cause];

endmodule

// File: rtl/core_trap_unit.sv
// Implicit CSR writer for exceptions, interrupts and xRET:
// capture in IDLE, wait for s2 to drain, commit CSRs, redirect fetch.
module core_trap_unit
    import core_pkg::*;
#(
    parameter int NUM_IRQ = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_req,
    input  logic [4:0]  exc_cause,
    input  logic [31:0] exc_epc,
    input  logic [31:0] exc_tval,
    input  logic        xret_req,
    input  logic        xret_is_mret,
    input  logic [31:0] mip_i,
    input  logic        s2_busy,
    input  logic [1:0]  prv_mode_ff,
    input  logic [31:0] csr_mstatus_ff,
    input  logic [31:0] csr_medeleg_ff,
    input  logic [31:0] csr_mideleg_ff,
    input  logic [31:0] csr_mie_ff,
    input  logic [31:0] csr_mtvec_ff,
    input  logic [31:0] csr_stvec_ff,
    input  logic [31:0] csr_mepc_ff,
    input  logic [31:0] csr_sepc_ff,
    output logic        trap_busy,
    output logic [1:0]  prv_mode_wd,
    output logic        prv_mode_we,
    output logic [31:0] csr_mstatus_wd,
    output logic        csr_mstatus_we,
    output logic [31:0] csr_mepc_wd,
    output logic        csr_mepc_we,
    output logic [31:0] csr_mcause_wd,
    output logic        csr_mcause_we,
    output logic [31:0] csr_mtval_wd,
    output logic        csr_mtval_we,
    output logic [31:0] csr_sepc_wd,
    output logic        csr_sepc_we,
    output logic [31:0] csr_scause_wd,
    output logic        csr_scause_we,
    output logic [31:0] csr_stval_wd,
    output logic        csr_stval_we,
    output logic [31:0] branch_target,
    output logic        branch_en,
    output logic        invalidate_fetch
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        COMMIT,
        REDIRECT
    } state_t;

    state_t     state;
    trap_kind_e cap_kind;
    logic [4:0] cap_cause;
    logic       cap_to_s;
    logic [1:0] cap_prv;
    logic [31:0] cap_epc;
    logic [31:0] cap_tval;
    logic [31:0] cap_mstatus;
    logic [31:0] cap_tgt;

    logic       irq_valid;
    logic [4:0] irq_cause;
    logic       irq_to_s;

    logic       unused_bits;
    assign unused_bits = ^{mip_i[31:NUM_IRQ], csr_mie_ff[31:NUM_IRQ],
                           csr_mideleg_ff[31:NUM_IRQ]};

    core_trap_irq_select #(
        .NUM_IRQ (NUM_IRQ)
    ) u_irq_select (
        .mip       (mip_i[NUM_IRQ-1:0]),
        .mie       (csr_mie_ff[NUM_IRQ-1:0]),
        .mideleg   (csr_mideleg_ff[NUM_IRQ-1:0]),
        .sie_en    (csr_mstatus_ff[MSTATUS_SIE]),
        .mie_en    (csr_mstatus_ff[MSTATUS_MIE]),
        .prv       (prv_mode_ff),
        .irq_valid (irq_valid),
        .irq_cause (irq_cause),
        .irq_to_s  (irq_to_s)
    );

    logic       sel_valid;
    trap_kind_e sel_kind;
    logic [4:0] sel_cause;
    logic       sel_to_s;
    logic [31:0] sel_tvec;
    logic [31:0] sel_base;
    logic [31:0] sel_tgt;

    always_comb begin
        sel_valid = 1'b0;
        sel_kind  = TRAP_EXC;
        sel_cause = exc_cause;
        sel_to_s  = 1'b0;
        sel_tgt   = '0;
        if (exc_req) begin
            sel_valid = 1'b1;
            sel_to_s  = (prv_mode_ff != PRV_M) && csr_medeleg_ff[exc_cause];
        end else if (irq_valid) begin
            sel_valid = 1'b1;
            sel_kind  = TRAP_IRQ;
            sel_cause = irq_cause;
            sel_to_s  = irq_to_s;
        end else if (xret_req) begin
            sel_valid = 1'b1;
            sel_kind  = xret_is_mret ? TRAP_MRET : TRAP_SRET;
        end
        sel_tvec = sel_to_s ? csr_stvec_ff : csr_mtvec_ff;
        sel_base = {sel_tvec[31:2], 2'b00};
        // MODE 1x is unsupported and falls back to direct.
        if (sel_kind == TRAP_MRET)
            sel_tgt = csr_mepc_ff;
        else if (sel_kind == TRAP_SRET)
            sel_tgt = csr_sepc_ff;
        else if (sel_kind == TRAP_IRQ && sel_tvec[1:0] == 2'b01)
            sel_tgt = sel_base + 32'({sel_cause, 2'b00});
        else
            sel_tgt = sel_base;
    end

    logic [31:0] nxt_mstatus;
    logic [1:0]  nxt_prv;
    logic        is_trap;
    logic [31:0] nxt_epc;
    logic [31:0] nxt_cause;
    logic [31:0] nxt_tval;

    always_comb begin
        nxt_mstatus = cap_mstatus;
        nxt_prv     = cap_prv;
        is_trap     = 1'b0;
        unique case (cap_kind)
            TRAP_EXC, TRAP_IRQ: begin
                is_trap = 1'b1;
                if (cap_to_s) begin
                    nxt_mstatus[MSTATUS_SPIE] = cap_mstatus[MSTATUS_SIE];
                    nxt_mstatus[MSTATUS_SIE]  = 1'b0;
                    nxt_mstatus[MSTATUS_SPP]  = cap_prv[0];
                    nxt_prv = PRV_S;
                end else begin
                    nxt_mstatus[MSTATUS_MPIE] = cap_mstatus[MSTATUS_MIE];
                    nxt_mstatus[MSTATUS_MIE]  = 1'b0;
                    nxt_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = cap_prv;
                    nxt_prv = PRV_M;
                end
            end
            TRAP_MRET: begin
                nxt_mstatus[MSTATUS_MIE]  = cap_mstatus[MSTATUS_MPIE];
                nxt_mstatus[MSTATUS_MPIE] = 1'b1;
                nxt_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRV_U;
                if (cap_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] != PRV_M)
                    nxt_mstatus[MSTATUS_MPRV] = 1'b0;
                nxt_prv = cap_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
            end
            TRAP_SRET: begin
                nxt_mstatus[MSTATUS_SIE]  = cap_mstatus[MSTATUS_SPIE];
                nxt_mstatus[MSTATUS_SPIE] = 1'b1;
                nxt_mstatus[MSTATUS_SPP]  = 1'b0;
                nxt_mstatus[MSTATUS_MPRV] = 1'b0;
                nxt_prv = {1'b0, cap_mstatus[MSTATUS_SPP]};
            end
        endcase
        nxt_epc   = {cap_epc[31:2], 2'b00};
        nxt_cause = {cap_kind == TRAP_IRQ, 26'b0, cap_cause};
        nxt_tval  = (cap_kind == TRAP_IRQ) ? 32'h0 : cap_tval;
    end

    assign trap_busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cap_kind         <= TRAP_EXC;
            cap_cause        <= '0;
            cap_to_s         <= 1'b0;
            cap_prv          <= '0;
            cap_epc          <= '0;
            cap_tval         <= '0;
            cap_mstatus      <= '0;
            cap_tgt          <= '0;
            prv_mode_wd      <= '0;
            prv_mode_we      <= 1'b0;
            csr_mstatus_wd   <= '0;
            csr_mstatus_we   <= 1'b0;
            csr_mepc_wd      <= '0;
            csr_mepc_we      <= 1'b0;
            csr_mcause_wd    <= '0;
            csr_mcause_we    <= 1'b0;
            csr_mtval_wd     <= '0;
            csr_mtval_we     <= 1'b0;
            csr_sepc_wd      <= '0;
            csr_sepc_we      <= 1'b0;
            csr_scause_wd    <= '0;
            csr_scause_we    <= 1'b0;
            csr_stval_wd     <= '0;
            csr_stval_we     <= 1'b0;
            branch_target    <= '0;
            branch_en        <= 1'b0;
            invalidate_fetch <= 1'b0;
        end else begin
            prv_mode_wd      <= '0;
            prv_mode_we      <= 1'b0;
            csr_mstatus_wd   <= '0;
            csr_mstatus_we   <= 1'b0;
            csr_mepc_wd      <= '0;
            csr_mepc_we      <= 1'b0;
            csr_mcause_wd    <= '0;
            csr_mcause_we    <= 1'b0;
            csr_mtval_wd     <= '0;
            csr_mtval_we     <= 1'b0;
            csr_sepc_wd      <= '0;
            csr_sepc_we      <= 1'b0;
            csr_scause_wd    <= '0;
            csr_scause_we    <= 1'b0;
            csr_stval_wd     <= '0;
            csr_stval_we     <= 1'b0;
            branch_target    <= '0;
            branch_en        <= 1'b0;
            invalidate_fetch <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sel_valid) begin
                        cap_kind    <= sel_kind;
                        cap_cause   <= sel_cause;
                        cap_to_s    <= sel_to_s;
                        cap_prv     <= prv_mode_ff;
                        cap_epc     <= exc_epc;
                        cap_tval    <= exc_tval;
                        cap_mstatus <= csr_mstatus_ff;
                        cap_tgt     <= sel_tgt;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!s2_busy) begin
                        state          <= COMMIT;
                        prv_mode_wd    <= nxt_prv;
                        prv_mode_we    <= 1'b1;
                        csr_mstatus_wd <= nxt_mstatus;
                        csr_mstatus_we <= 1'b1;
                        if (is_trap && !cap_to_s) begin
                            csr_mepc_wd   <= nxt_epc;
                            csr_mepc_we   <= 1'b1;
                            csr_mcause_wd <= nxt_cause;
                            csr_mcause_we <= 1'b1;
                            csr_mtval_wd  <= nxt_tval;
                            csr_mtval_we  <= 1'b1;
                        end
                        if (is_trap && cap_to_s) begin
                            csr_sepc_wd   <= nxt_epc;
                            csr_sepc_we   <= 1'b1;
                            csr_scause_wd <= nxt_cause;
                            csr_scause_we <= 1'b1;
                            csr_stval_wd  <= nxt_tval;
                            csr_stval_we  <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    state            <= REDIRECT;
                    branch_target    <= cap_tgt;
                    branch_en        <= 1'b1;
                    invalidate_fetch <= 1'b1;
                end
                REDIRECT: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_trap_unit.sv
// Scoreboard bench for core_trap_unit: expected CSR commits and
// redirects are queued at stimulus time and checked on output.
module tb_core_trap_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_req;
    logic [4:0]  exc_cause;
    logic [31:0] exc_epc;
    logic [31:0] exc_tval;
    logic        xret_req;
    logic        xret_is_mret;
    logic [31:0] mip_i;
    logic        s2_busy;
    logic [1:0]  prv_mode_ff;
    logic [31:0] csr_mstatus_ff, csr_medeleg_ff, csr_mideleg_ff, csr_mie_ff;
    logic [31:0] csr_mtvec_ff, csr_stvec_ff, csr_mepc_ff, csr_sepc_ff;
    logic        trap_busy;
    logic [1:0]  prv_mode_wd;
    logic        prv_mode_we;
    logic [31:0] csr_mstatus_wd, csr_mepc_wd, csr_mcause_wd, csr_mtval_wd;
    logic [31:0] csr_sepc_wd, csr_scause_wd, csr_stval_wd;
    logic        csr_mstatus_we, csr_mepc_we, csr_mcause_we, csr_mtval_we;
    logic        csr_sepc_we, csr_scause_we, csr_stval_we;
    logic [31:0] branch_target;
    logic        branch_en;
    logic        invalidate_fetch;

    core_trap_unit #(.NUM_IRQ(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .exc_req(exc_req), .exc_cause(exc_cause),
        .exc_epc(exc_epc), .exc_tval(exc_tval),
        .xret_req(xret_req), .xret_is_mret(xret_is_mret),
        .mip_i(mip_i), .s2_busy(s2_busy), .prv_mode_ff(prv_mode_ff),
        .csr_mstatus_ff(csr_mstatus_ff), .csr_medeleg_ff(csr_medeleg_ff),
        .csr_mideleg_ff(csr_mideleg_ff), .csr_mie_ff(csr_mie_ff),
        .csr_mtvec_ff(csr_mtvec_ff), .csr_stvec_ff(csr_stvec_ff),
        .csr_mepc_ff(csr_mepc_ff), .csr_sepc_ff(csr_sepc_ff),
        .trap_busy(trap_busy),
        .prv_mode_wd(prv_mode_wd), .prv_mode_we(prv_mode_we),
        .csr_mstatus_wd(csr_mstatus_wd), .csr_mstatus_we(csr_mstatus_we),
        .csr_mepc_wd(csr_mepc_wd), .csr_mepc_we(csr_mepc_we),
        .csr_mcause_wd(csr_mcause_wd), .csr_mcause_we(csr_mcause_we),
        .csr_mtval_wd(csr_mtval_wd), .csr_mtval_we(csr_mtval_we),
        .csr_sepc_wd(csr_sepc_wd), .csr_sepc_we(csr_sepc_we),
        .csr_scause_wd(csr_scause_wd), .csr_scause_we(csr_scause_we),
        .csr_stval_wd(csr_stval_wd), .csr_stval_we(csr_stval_we),
        .branch_target(branch_target), .branch_en(branch_en),
        .invalidate_fetch(invalidate_fetch)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          redir;
        int          cyc;
        logic [7:0]  we;
        logic [1:0]  prv;
        logic [31:0] mst;
        logic [31:0] epc;
        logic [31:0] cause;
        logic [31:0] tval;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] we_vec();
        return {prv_mode_we, csr_mstatus_we, csr_mepc_we, csr_mcause_we,
                csr_mtval_we, csr_sepc_we, csr_scause_we, csr_stval_we};
    endfunction

    // Called on the negedge where the request is driven (cycle N).
    task automatic expect_trap(input logic [7:0] we, input logic [1:0] prv,
                               input logic [31:0] mst, input logic [31:0] epc,
                               input logic [31:0] cause, input logic [31:0] tval,
                               input logic [31:0] tgt, input int extra,
                               input bit redir);
        exp_t e;
        e.redir = 1'b0;
        e.cyc   = cyc + 2 + extra;
        e.we    = we;
        e.prv   = prv;
        e.mst   = mst;
        e.epc   = epc;
        e.cause = cause;
        e.tval  = tval;
        e.tgt   = '0;
        sb.push_back(e);
        if (redir) begin
            e.redir = 1'b1;
            e.cyc   = cyc + 3 + extra;
            e.tgt   = tgt;
            sb.push_back(e);
        end
    endtask

    logic [7:0] mon_we;
    exp_t       mon_e;

    always @(negedge clk) begin
        mon_we = we_vec();
        if (rst_n && mon_we != 8'h0) begin
            if (sb.size() == 0) begin
                chk("spurious_we", 32'(mon_we), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                chk("c_kind", 32'(mon_e.redir), 32'h0);
                chk("c_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("c_we", 32'(mon_we), 32'(mon_e.we));
                chk("c_prv", 32'(prv_mode_wd), 32'(mon_e.prv));
                chk("c_mstatus", csr_mstatus_wd, mon_e.mst);
                if (mon_e.we[5]) begin
                    chk("mepc", csr_mepc_wd, mon_e.epc);
                    chk("mcause", csr_mcause_wd, mon_e.cause);
                    chk("mtval", csr_mtval_wd, mon_e.tval);
                end
                if (mon_e.we[2]) begin
                    chk("sepc", csr_sepc_wd, mon_e.epc);
                    chk("scause", csr_scause_wd, mon_e.cause);
                    chk("stval", csr_stval_wd, mon_e.tval);
                end
            end
        end
        if (rst_n && branch_en) begin
            if (sb.size() == 0) begin
                chk("spurious_redir", 32'(branch_en), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                chk("r_kind", 32'(mon_e.redir), 32'h1);
                chk("r_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("r_target", branch_target, mon_e.tgt);
                chk("r_inval", 32'(invalidate_fetch), 32'h1);
                chk("r_no_we", 32'(mon_we), 32'h0);
            end
        end
    end

    task automatic pulse_req(input logic exc, input logic xret,
                             input logic mret, input logic [31:0] irq);
        exc_req      = exc;
        xret_req     = xret;
        xret_is_mret = mret;
        mip_i        = irq;
        @(negedge clk);
        exc_req  = 1'b0;
        xret_req = 1'b0;
        mip_i    = '0;
        chk("busy_n1", 32'(trap_busy), 32'h1);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((trap_busy || sb.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout", 32'(n >= 40), 32'h0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        exc_req = 0; exc_cause = '0; exc_epc = '0; exc_tval = '0;
        xret_req = 0; xret_is_mret = 0; mip_i = '0; s2_busy = 0;
        prv_mode_ff = 2'b00;
        csr_mstatus_ff = '0; csr_medeleg_ff = '0; csr_mideleg_ff = '0;
        csr_mie_ff = '0; csr_mtvec_ff = '0; csr_stvec_ff = '0;
        csr_mepc_ff = '0; csr_sepc_ff = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(trap_busy), 32'h0);
        chk("rst_we", 32'(we_vec()), 32'h0);
        chk("rst_mst_wd", csr_mstatus_wd, 32'h0);
        chk("rst_br_en", 32'(branch_en), 32'h0);
        chk("rst_inval", 32'(invalidate_fetch), 32'h0);
        chk("rst_target", branch_target, 32'h0);
        rst_n = 1'b1;

        // Illegal instruction from U to M.
        @(negedge clk);
        prv_mode_ff = 2'b00; csr_mstatus_ff = 32'h8;
        csr_mtvec_ff = 32'h8000_0100; csr_stvec_ff = 32'h8000_0200;
        exc_cause = 5'd2; exc_epc = 32'h1000; exc_tval = 32'hdead;
        expect_trap(8'hF8, 2'b11, 32'h80, 32'h1000, 32'h2, 32'hdead,
                    32'h8000_0100, 0, 1'b1);
        pulse_req(1'b1, 1'b0, 1'b0, '0);
        wait_done();

        // Same exception delegated to S.
        csr_medeleg_ff = 32'h4; csr_mstatus_ff = 32'hA;
        expect_trap(8'hC7, 2'b01, 32'h28, 32'h1000, 32'h2, 32'hdead,
                    32'h8000_0200, 0, 1'b1);
        pulse_req(1'b1, 1'b0, 1'b0, '0);
        wait_done();

        // Delegated SSI+STI, vectored stvec: SSI wins.
        csr_medeleg_ff = '0; csr_mideleg_ff = 32'h22; csr_mie_ff = 32'h22;
        csr_mstatus_ff = 32'h2; csr_stvec_ff = 32'h8000_0201;
        exc_epc = 32'h5000; exc_tval = 32'h1234;
        expect_trap(8'hC7, 2'b01, 32'h20, 32'h5000, 32'h8000_0001, 32'h0,
                    32'h8000_0204, 0, 1'b1);
        pulse_req(1'b0, 1'b0, 1'b0, 32'h22);
        wait_done();

        // MTI in M, vectored mtvec, epc low bits dropped.
        csr_mideleg_ff = '0; csr_mie_ff = 32'h80; csr_mstatus_ff = 32'h8;
        csr_mtvec_ff = 32'h8000_0001; prv_mode_ff = 2'b11;
        exc_epc = 32'h2002; exc_tval = 32'hbeef;
        expect_trap(8'hF8, 2'b11, 32'h1880, 32'h2000, 32'h8000_0007, 32'h0,
                    32'h8000_001C, 0, 1'b1);
        pulse_req(1'b0, 1'b0, 1'b0, 32'h80);
        wait_done();

        // MTI masked by MIE=0 in M.
        csr_mstatus_ff = '0; mip_i = 32'h80;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("masked_irq_busy", 32'(trap_busy), 32'h0);
        end
        mip_i = '0;

        // Exception beats simultaneous MEI.
        @(negedge clk);
        csr_mstatus_ff = 32'h8; prv_mode_ff = 2'b00; csr_mie_ff = 32'h800;
        exc_cause = 5'd2; exc_epc = 32'h6000; exc_tval = 32'h77;
        expect_trap(8'hF8, 2'b11, 32'h80, 32'h6000, 32'h2, 32'h77,
                    32'h8000_0000, 0, 1'b1);
        pulse_req(1'b1, 1'b0, 1'b0, 32'h800);
        wait_done();

        // MRET back to S.
        csr_mie_ff = '0; prv_mode_ff = 2'b11;
        csr_mstatus_ff = 32'h0002_0880; csr_mepc_ff = 32'h3000;
        expect_trap(8'hC0, 2'b01, 32'h88, 32'h0, 32'h0, 32'h0,
                    32'h3000, 0, 1'b1);
        pulse_req(1'b0, 1'b1, 1'b1, '0);
        wait_done();

        // SRET back to S (SPP=1).
        prv_mode_ff = 2'b01; csr_mstatus_ff = 32'h0002_0120;
        csr_sepc_ff = 32'h4000;
        expect_trap(8'hC0, 2'b01, 32'h22, 32'h0, 32'h0, 32'h0,
                    32'h4000, 0, 1'b1);
        pulse_req(1'b0, 1'b1, 1'b0, '0);
        wait_done();

        // s2_busy held for five cycles after the request.
        prv_mode_ff = 2'b00; csr_mstatus_ff = 32'h8;
        csr_mtvec_ff = 32'h8000_0100;
        exc_cause = 5'd8; exc_epc = 32'h7004; exc_tval = 32'h0;
        s2_busy = 1'b1;
        expect_trap(8'hF8, 2'b11, 32'h80, 32'h7004, 32'h8, 32'h0,
                    32'h8000_0100, 5, 1'b1);
        pulse_req(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_busy", 32'(trap_busy), 32'h1);
        end
        @(negedge clk);
        s2_busy = 1'b0;
        wait_done();

        // Reset during COMMIT aborts the redirect.
        exc_cause = 5'd2; exc_epc = 32'h8000; exc_tval = 32'h55;
        expect_trap(8'hF8, 2'b11, 32'h80, 32'h8000, 32'h2, 32'h55,
                    32'h8000_0100, 0, 1'b0);
        pulse_req(1'b1, 1'b0, 1'b0, '0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_we", 32'(we_vec()), 32'h0);
        chk("abort_mst_wd", csr_mstatus_wd, 32'h0);
        chk("abort_busy", 32'(trap_busy), 32'h0);
        chk("abort_br_en", 32'(branch_en), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_no_redir", 32'(branch_en), 32'h0);
        end

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
